// File: rtl/dma_xfer_engine_pkg.sv
// dma_xfer_engine_pkg
// Purpose: shared state encoding and default widths for the DMA transfer engine.
// Contents: state_t (IDLE/READ/WRITE/DONE), DEF_ADDR_W, DEF_DATA_W, DEF_LEN_W.
package dma_xfer_engine_pkg;

   localparam int unsigned DEF_ADDR_W = 8;
   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_LEN_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage : dma_xfer_engine_pkg

// File: rtl/dma_xfer_engine_if.sv
// dma_xfer_engine_if
// Purpose: groups the start-register side and the memory side of the DMA engine.
// Signals:
//   start, src_addr, dst_addr, len   launch request from the start-register stage
//   rd_en, rd_addr, rd_data          memory read port (data one cycle after rd_en)
//   wr_en, wr_addr, wr_data          memory write port
//   busy, done, err                  engine status
// Modports: master = the engine, slave = start register + memory environment.
interface dma_xfer_engine_if
   import dma_xfer_engine_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned LEN_W  = DEF_LEN_W
);

   logic              start;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] dst_addr;
   logic [LEN_W-1:0]  len;

   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   logic              busy;
   logic              done;
   logic              err;

   modport master (
      input  start, src_addr, dst_addr, len, rd_data,
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, err
   );

   modport slave (
      output start, src_addr, dst_addr, len, rd_data,
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, err
   );

endinterface : dma_xfer_engine_if

// File: rtl/dma_xfer_engine_start_edge_det.sv
// dma_xfer_engine_start_edge_det
// Purpose: registers the start level and flags its 0->1 transition.
// Ports:
//   i_clk       system clock
//   i_rst       asynchronous active-high reset
//   i_start     registered start level
//   o_launch_c  combinational launch pulse (start & ~start_q)
module dma_xfer_engine_start_edge_det (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_start,
   output logic o_launch_c
);

   logic r_start_q;

   // Tracks start every cycle, busy or not, so a held level never relaunches.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_start_q <= 1'b0;
      end else begin
         r_start_q <= i_start;
      end
   end

   assign o_launch_c = i_start & ~r_start_q;

endmodule : dma_xfer_engine_start_edge_det

// File: rtl/dma_xfer_engine.sv
// dma_xfer_engine
// Purpose: on a rising start edge, copies len words from src_addr to dst_addr,
//          one read cycle plus one write cycle per word, then pulses done.
// Ports:
//   i_clk  system clock
//   i_rst  asynchronous active-high reset
//   bus    dma_xfer_engine_if.master (start/addresses/len in, memory ports out,
//          busy/done/err status out)
// Build option: DMA_BOUND_CHECK_EN enables the launch-time address bound check
//          (violation -> straight to DONE with err set); otherwise err is 0.
module dma_xfer_engine
   import dma_xfer_engine_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned LEN_W  = DEF_LEN_W
)(
   input  logic                i_clk,
   input  logic                i_rst,
   dma_xfer_engine_if.master   bus
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_cur_src;
   logic [ADDR_W-1:0] r_cur_dst;
   logic [LEN_W-1:0]  r_count;
   logic              w_launch;
   logic              w_bound_err;
   logic              w_rd_en;
   logic              w_wr_en;

   dma_xfer_engine_start_edge_det u_start_edge_det (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_start    (bus.start),
      .o_launch_c (w_launch)
   );

`ifdef DMA_BOUND_CHECK_EN
   localparam int unsigned       AW1      = ADDR_W + 1;
   localparam logic [ADDR_W:0]   LP_SPACE = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W:0] w_src_end;
   logic [ADDR_W:0] w_dst_end;
   logic            r_err;

   // One extra bit so an end address of exactly 2^ADDR_W is still legal.
   assign w_src_end   = {1'b0, bus.src_addr} + AW1'(bus.len);
   assign w_dst_end   = {1'b0, bus.dst_addr} + AW1'(bus.len);
   assign w_bound_err = (w_src_end > LP_SPACE) || (w_dst_end > LP_SPACE);

   // Error flag holds until the next accepted launch.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_err <= 1'b0;
      end else if ((r_state == ST_IDLE) && w_launch) begin
         r_err <= w_bound_err;
      end
   end

   assign bus.err = r_err;
`else
   assign w_bound_err = 1'b0;
   assign bus.err     = 1'b0;
`endif

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; launches outside IDLE are dropped.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_launch) begin
               if ((bus.len == '0) || w_bound_err) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt = ST_READ;
               end
            end
         end
         ST_READ:  w_state_nxt = ST_WRITE;
         ST_WRITE: w_state_nxt = (r_count == LEN_W'(1)) ? ST_DONE : ST_READ;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Address/count datapath: latched on launch, stepped once per written word.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cur_src <= '0;
         r_cur_dst <= '0;
         r_count   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_launch) begin
                  r_cur_src <= bus.src_addr;
                  r_cur_dst <= bus.dst_addr;
                  r_count   <= bus.len;
               end
            end
            ST_WRITE: begin
               r_cur_src <= r_cur_src + ADDR_W'(1);
               r_cur_dst <= r_cur_dst + ADDR_W'(1);
               r_count   <= r_count - LEN_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Strobes and status come from the state register alone.
   assign w_rd_en = (r_state == ST_READ);
   assign w_wr_en = (r_state == ST_WRITE);

   assign bus.rd_en   = w_rd_en;
   assign bus.wr_en   = w_wr_en;
   assign bus.busy    = (r_state != ST_IDLE);
   assign bus.done    = (r_state == ST_DONE);

   // Address/data forced to zero while their strobe is low so reset leaves all outputs at 0.
   assign bus.rd_addr = w_rd_en ? r_cur_src   : ADDR_W'(0);
   assign bus.wr_addr = w_wr_en ? r_cur_dst   : ADDR_W'(0);
   assign bus.wr_data = w_wr_en ? bus.rd_data : DATA_W'(0);

endmodule : dma_xfer_engine

// File: tb/tb_dma_xfer_engine.sv
// tb_dma_xfer_engine
// Purpose: directed, table-driven bench for dma_xfer_engine with a read-only
//          source memory model and a negedge monitor logging strobes and status.
module tb_dma_xfer_engine;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   dma_xfer_engine_if #(.ADDR_W(8), .DATA_W(8), .LEN_W(8)) bus ();

   dma_xfer_engine #(.ADDR_W(8), .DATA_W(8), .LEN_W(8)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // Source memory: written only by the stimulus, read synchronously by the model.
   logic [7:0] mem_src [256];

   always @(posedge clk) begin
      if (bus.rd_en) bus.rd_data <= mem_src[bus.rd_addr];
   end

   // Edge counter: after edge k, e == k.
   int e = 0;
   always @(posedge clk) e <= e + 1;

   // Monitor: the cycle following edge k is labelled k+1.
   logic [7:0] rd_q[$];
   logic [7:0] wa_q[$];
   logic [7:0] wd_q[$];
   int         done_q[$];
   logic       err_q[$];
   int         busy_cnt = 0;

   always @(negedge clk) begin
      if (bus.rd_en) rd_q.push_back(bus.rd_addr);
      if (bus.wr_en) begin
         wa_q.push_back(bus.wr_addr);
         wd_q.push_back(bus.wr_data);
      end
      if (bus.done) begin
         done_q.push_back(e + 1);
         err_q.push_back(bus.err);
      end
      if (bus.busy) busy_cnt = busy_cnt + 1;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0] src;
      logic [7:0] dst;
      logic [7:0] len;
      logic [7:0] seed;
      int         lat;   // cycles from launch edge to done cycle
      logic       err;
   } vec_t;

   vec_t tbl [6];

   task automatic preload(input logic [7:0] src, input logic [7:0] len, input logic [7:0] seed);
      for (int i = 0; i < int'(len); i++) begin
         mem_src[8'(src + 8'(i))] = 8'(seed + 8'(i) * 8'h11);
      end
   endtask

   // One transfer: launches at the next edge, returns in the done cycle with start low.
   task automatic run_vec(input vec_t v, input string nm);
      int  rb, wb, db, bb, k, n;
      bit  got;
      @(posedge clk); #1;
      preload(v.src, v.len, v.seed);
      bus.src_addr = v.src;
      bus.dst_addr = v.dst;
      bus.len      = v.len;
      bus.start    = 1'b1;
      rb = rd_q.size(); wb = wa_q.size(); db = done_q.size(); bb = busy_cnt;
      k  = e + 1;
      @(posedge clk); #1;
      // Post-launch input changes must be ignored.
      bus.src_addr = ~v.src;
      bus.dst_addr = ~v.dst;
      bus.len      = v.len + 8'd5;
      got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk); #1;
         if (done_q.size() > db) got = 1'b1;
      end
      bus.start = 1'b0;
      if (!got) begin
         n_checks = n_checks + 1;
         n_errors = n_errors + 1;
         $display("FAIL %s timeout: no done within 200 cycles", nm);
      end else begin
         n = v.err ? 0 : int'(v.len);
         chk({nm, " done_lat"}, 32'(done_q[db] - k), 32'(v.lat));
         chk({nm, " busy_cycles"}, 32'(busy_cnt - bb), 32'(v.lat));
         chk({nm, " err"}, 32'(err_q[db]), 32'(v.err));
         chk({nm, " rd_count"}, 32'(rd_q.size() - rb), 32'(n));
         chk({nm, " wr_count"}, 32'(wa_q.size() - wb), 32'(n));
         if ((rd_q.size() - rb == n) && (wa_q.size() - wb == n)) begin
            for (int i = 0; i < n; i++) begin
               chk({nm, " rd_addr"}, 32'(rd_q[rb + i]), 32'(8'(v.src + 8'(i))));
               chk({nm, " wr_addr"}, 32'(wa_q[wb + i]), 32'(8'(v.dst + 8'(i))));
               chk({nm, " wr_data"}, 32'(wd_q[wb + i]), 32'(8'(v.seed + 8'(i) * 8'h11)));
            end
         end
      end
   endtask

   initial begin
      int rb, wb, db, bb, k, nw;

      tbl[0] = '{8'h10, 8'h80, 8'd3, 8'hA1, 7, 1'b0};
      tbl[1] = '{8'h20, 8'h40, 8'd1, 8'h3C, 3, 1'b0};
      tbl[2] = '{8'h30, 8'h50, 8'd0, 8'h77, 1, 1'b0};
`ifdef DMA_BOUND_CHECK_EN
      tbl[3] = '{8'hFE, 8'h60, 8'd4, 8'hC0, 1, 1'b1};
`else
      tbl[3] = '{8'hFE, 8'h60, 8'd4, 8'hC0, 9, 1'b0};
`endif
      tbl[4] = '{8'hFC, 8'h00, 8'd4, 8'h08, 9, 1'b0};
`ifdef DMA_BOUND_CHECK_EN
      tbl[5] = '{8'hF0, 8'hFD, 8'd5, 8'h40, 1, 1'b1};
`else
      tbl[5] = '{8'hF0, 8'hFD, 8'd5, 8'h40, 11, 1'b0};
`endif

      for (int i = 0; i < 256; i++) mem_src[i] = 8'h00;

      // Reset state.
      rst = 1'b1;
      bus.start = 1'b0; bus.src_addr = 8'h00; bus.dst_addr = 8'h00; bus.len = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst rd_en",   32'(bus.rd_en),   32'h0);
      chk("rst wr_en",   32'(bus.wr_en),   32'h0);
      chk("rst busy",    32'(bus.busy),    32'h0);
      chk("rst done",    32'(bus.done),    32'h0);
      chk("rst err",     32'(bus.err),     32'h0);
      chk("rst addrs",   32'({bus.rd_addr, bus.wr_addr, bus.wr_data}), 32'h0);
      rst = 1'b0;

      // Table: consecutive runs are back-to-back (start low only during DONE).
      for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // Start held high with a second rising edge mid-transfer: one transfer only.
      @(posedge clk); #1;
      preload(8'h70, 8'd4, 8'h5A);
      bus.src_addr = 8'h70; bus.dst_addr = 8'hA0; bus.len = 8'd4; bus.start = 1'b1;
      rb = rd_q.size(); wb = wa_q.size(); db = done_q.size(); bb = busy_cnt;
      k = e + 1;
      for (int c = 0; c < 25; c++) begin
         @(posedge clk); #1;
         if (c == 2) bus.start = 1'b0;
         if (c == 3) bus.start = 1'b1;
      end
      chk("hold done_count", 32'(done_q.size() - db), 32'd1);
      chk("hold wr_count",   32'(wa_q.size() - wb), 32'd4);
      chk("hold rd_count",   32'(rd_q.size() - rb), 32'd4);
      chk("hold busy_cycles", 32'(busy_cnt - bb), 32'd9);
      chk("hold busy_now",   32'(bus.busy), 32'h0);
      if (done_q.size() > db) chk("hold done_lat", 32'(done_q[db] - k), 32'd9);
      if (wa_q.size() - wb == 4) begin
         chk("hold last wr_addr", 32'(wa_q[wb + 3]), 32'h0A3);
         chk("hold last wr_data", 32'(wd_q[wb + 3]), 32'h08D);
      end
      bus.start = 1'b0;

      // Reset asserted in the second WRITE cycle of a 4-word transfer.
      @(posedge clk); #1;
      @(posedge clk); #1;
      preload(8'h40, 8'd4, 8'h11);
      bus.src_addr = 8'h40; bus.dst_addr = 8'h90; bus.len = 8'd4; bus.start = 1'b1;
      rb = rd_q.size(); wb = wa_q.size();
      nw = 0;
      for (int c = 0; c < 20 && nw < 2; c++) begin
         @(posedge clk); #1;
         if (bus.wr_en) nw = nw + 1;
      end
      if (nw < 2) begin
         n_checks = n_checks + 1;
         n_errors = n_errors + 1;
         $display("FAIL midrst timeout: second WRITE not reached");
      end
      rst = 1'b1;
      bus.start = 1'b0;
      #1;
      chk("midrst rd_en", 32'(bus.rd_en), 32'h0);
      chk("midrst wr_en", 32'(bus.wr_en), 32'h0);
      chk("midrst busy",  32'(bus.busy),  32'h0);
      chk("midrst done",  32'(bus.done),  32'h0);
      chk("midrst addrs", 32'({bus.rd_addr, bus.wr_addr, bus.wr_data}), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("midrst wr_count", 32'(wa_q.size() - wb), 32'd1);
      chk("midrst rd_count", 32'(rd_q.size() - rb), 32'd2);
      chk("midrst busy_after", 32'(bus.busy), 32'h0);
      if (wa_q.size() - wb == 1) begin
         chk("midrst partial addr", 32'(wa_q[wb]), 32'h090);
         chk("midrst partial data", 32'(wd_q[wb]), 32'h011);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_dma_xfer_engine
